// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : CPU-bus snooping UART transmitter with a power-of-two byte
//               FIFO. Sends 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] DATA_ADDR  = 16'hFFF0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wen,
    input  logic [15:0]           waddr,
    input  logic [15:0]           wdata,
    input  logic                  clr_ovf,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf
);

    localparam int c_DIV   = CLK_HZ / BAUD;
    localparam int c_CNT_W = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_PTR_W = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic [c_PTR_W-1:0]   wptr_q, wptr_d;
    logic [c_PTR_W-1:0]   rptr_q, rptr_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic [7:0]           mem [c_DEPTH];

    logic [c_PTR_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_hit;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_end;
    logic [7:0]           w_head;
    logic                 w_unused_hi;

    assign w_count    = wptr_q - rptr_q;
    assign w_full     = (w_count == c_PTR_W'(c_DEPTH));
    assign w_empty    = (w_count == '0);
    assign w_wr_hit   = wen && (waddr == DATA_ADDR);
    // Fullness is judged before any same-cycle pop, so a write into a full FIFO drops.
    assign w_push     = w_wr_hit && !w_full;
    assign w_pop      = (state_q == S_IDLE) && !w_empty;
    assign w_baud_end = (cnt_q == c_CNT_W'(c_DIV - 1));
    assign w_head     = mem[rptr_q[DEPTH_LOG2-1:0]];
    assign w_unused_hi = ^wdata[15:8];

    always_comb begin
        state_d = state_q;
        cnt_d   = w_baud_end ? '0 : cnt_q + c_CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (w_pop) begin
                    state_d = S_START;
                    shift_d = w_head;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        wptr_d = wptr_q + c_PTR_W'(w_push);
        rptr_d = rptr_q + c_PTR_W'(w_pop);

        // A dropped write beats a same-cycle clear.
        if (w_wr_hit && w_full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wptr_q[DEPTH_LOG2-1:0]] <= wdata[7:0];
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign count = w_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo (DIV=8, depth 4); honours
//               UART_TX_PARITY_EN for the 8E1 frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DIV   = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wen = 1'b0;
    logic [15:0] waddr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        clr_ovf = 1'b0;
    logic        tx;
    logic        busy;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    uart_tx_fifo #(
        .CLK_HZ     (8),
        .BAUD       (1),
        .DEPTH_LOG2 (2),
        .DATA_ADDR  (16'hFFF0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .clr_ovf (clr_ovf),
        .tx      (tx),
        .busy    (busy),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Reference: a byte queue plus a frame timer; the line level is derived
    // from elapsed time within the frame.
    logic [7:0] q[$];
    bit         m_active = 1'b0;
    int         m_rem = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    task automatic model_step();
        bit was_full;
        bit was_empty;
        bit drop;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        drop      = 1'b0;
        if (!reset_n) begin
            q.delete();
            m_active = 1'b0;
            m_rem    = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) m_active = 1'b0;
            end else if (!was_empty) begin
                m_cur    = q.pop_front();
                m_active = 1'b1;
                m_rem    = FRAME;
            end
            if (wen && waddr == 16'hFFF0) begin
                if (was_full) drop = 1'b1;
                else q.push_back(wdata[7:0]);
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = (FRAME - m_rem) / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_tx",    {31'd0, tx},    {31'd0, exp_tx()});
        chk("model_busy",  {31'd0, busy},  {31'd0, m_active});
        chk("model_count", {29'd0, count}, q.size());
        chk("model_full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
        chk("model_empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("model_ovf",   {31'd0, ovf},   {31'd0, m_ovf});
    endtask

    task automatic set_in(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic c);
        reset_n = r; wen = w; waddr = a; wdata = d; clr_ovf = c;
    endtask

    task automatic idle_cycles(input int n);
        set_in(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        set_in(1'b1, 1'b1, 16'hFFF0, {8'hEE, b}, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic drain();
        idle_cycles((DEPTH + 1) * (FRAME + 1) + 4);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic parity_frame(input logic [7:0] b, input logic exp_par);
        write_byte(b);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i == 9 * DIV + DIV / 2) chk("parity_bit", {31'd0, tx}, {31'd0, exp_par});
        end
        tick();
        chk("parity_frame_end_busy", {31'd0, busy}, 32'd0);
    endtask
`endif

    typedef struct {
        logic        rst_n;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        c;
        logic [2:0]  e_count;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_busy;
        logic        e_tx;
    } vec_t;

    vec_t tbl[12];
    logic [10:0] pat;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 16'hFFF1, 16'h0055, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 16'hFFF0, 16'h0011, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 16'hFFF0, 16'h0022, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'hFFF0, 16'hAB33, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'hFFF0, 16'h0044, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 16'hFFF0, 16'h0055, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'hFFF0, 16'h0066, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 16'hFFF0, 16'h0077, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].rst_n, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].c);
            tick();
            chk("tbl_count", {29'd0, count}, {29'd0, tbl[i].e_count});
            chk("tbl_empty", {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk("tbl_full",  {31'd0, full},  {31'd0, tbl[i].e_full});
            chk("tbl_ovf",   {31'd0, ovf},   {31'd0, tbl[i].e_ovf});
            chk("tbl_busy",  {31'd0, busy},  {31'd0, tbl[i].e_busy});
            chk("tbl_tx",    {31'd0, tx},    {31'd0, tbl[i].e_tx});
        end
        drain();
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Single frame of 0x68 with the exact bit pattern on the line.
`ifdef UART_TX_PARITY_EN
        pat = 11'b1_1_01101000_0;
`else
        pat = 11'b0_1_01101000_0;
`endif
        write_byte(8'h68);
        chk("f68_count_after_write", {29'd0, count}, 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            tick();
            chk("f68_tx",   {31'd0, tx},   {31'd0, pat[i / DIV]});
            chk("f68_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("f68_busy_end", {31'd0, busy}, 32'd0);
        chk("f68_tx_end",   {31'd0, tx},   32'd1);

        // Reset mid-DATA abandons the frame and clears the queue.
        write_byte(8'hA5);
        write_byte(8'h3C);
        idle_cycles(30);
        set_in(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        chk("rst_mid_tx",    {31'd0, tx},    32'd1);
        chk("rst_mid_busy",  {31'd0, busy},  32'd0);
        chk("rst_mid_count", {29'd0, count}, 32'd0);
        idle_cycles(3);
        write_byte(8'hA5);
        idle_cycles(FRAME + 3);
        chk("rst_clean_idle", {31'd0, busy}, 32'd0);

        // Fill and drain DEPTH+3 bytes across pointer wrap.
        begin
            int sent;
            sent = 0;
            for (int cyc = 0; cyc < 2000 && sent < DEPTH + 3; cyc++) begin
                if (q.size() < DEPTH && ($urandom_range(0, 3) != 0)) begin
                    write_byte(8'hC0 + 8'(sent));
                    sent++;
                end else begin
                    idle_cycles(1);
                end
            end
            chk("wrap_all_sent", sent, DEPTH + 3);
        end
        drain();
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        chk("wrap_busy",  {31'd0, busy},  32'd0);

`ifdef UART_TX_PARITY_EN
        parity_frame(8'h07, 1'b1);
        parity_frame(8'h03, 1'b0);
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            set_in(($urandom_range(0, 399) != 0),
                   ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFF0,
                   16'($urandom),
                   ($urandom_range(0, 15) == 0));
            tick();
        end
        drain();
        chk("final_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
